// File: rtl/img_row_streamer.sv
// Frame-buffered pixel row feeder: streams a prefill burst of rows after start,
// then releases one more row per rising edge of the engine's request line.
module img_row_streamer #(
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int PIX_W        = 8,
    parameter int PREFILL_ROWS = 4,
    parameter int FLIP_V       = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                              axi_clk,
    input  logic                              axi_rst_n,
    input  logic                              i_wr_en,
    input  logic [$clog2(IMG_W*IMG_H)-1:0]    i_wr_addr,
    input  logic [PIX_W-1:0]                  i_wr_data,
    input  logic                              i_start,
    input  logic                              i_abort,
    input  logic                              i_intr,
    output logic [PIX_W-1:0]                  o_data,
    output logic                              o_data_valid,
    output logic [$clog2(IMG_H)-1:0]          o_row_idx,
    output logic                              o_busy,
    output logic                              o_done
);
    localparam int AW = $clog2(IMG_W*IMG_H);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int NW = $clog2(IMG_H+1);
    localparam int GW = $clog2(GAP_CYCLES+1);

    if (PREFILL_ROWS < 1 || PREFILL_ROWS > IMG_H || GAP_CYCLES < 1) begin : g_bad_params
        $error("img_row_streamer: PREFILL_ROWS must be 1..IMG_H and GAP_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_GAP     = 3'd2,
        S_WAIT    = 3'd3,
        S_ROW     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     row_q, row_d;
    logic [NW-1:0]     pend_q, pend_d;
    logic [CW-1:0]     col_q, col_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              start_q, start_d;
    logic              intr_q, intr_d;
    logic              intr_prev_q, intr_prev_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [RW-1:0]     row_idx_q, row_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PIX_W-1:0]  mem_q [IMG_W*IMG_H];

    logic              streaming_s, edge_s, last_issued_s, inc_s, dec_s, clear_pend_s, wr_ok_s;
    logic [AW-1:0]     phys_row_s, rd_addr_s;

    // Next-state, row/column counters, request bookkeeping and output staging
    always_comb begin
        edge_s        = intr_q & ~intr_prev_q;
        streaming_s   = (state_q == S_PREFILL) || (state_q == S_ROW);
        // once the final row has been issued, further requests are meaningless
        last_issued_s = (streaming_s && (row_q == NW'(IMG_H-1))) ||
                        ((state_q == S_GAP) && (row_q == NW'(IMG_H)));
        inc_s         = edge_s && (streaming_s || (state_q == S_GAP)) &&
                        !last_issued_s && (pend_q < NW'(IMG_H));
        dec_s         = 1'b0;
        clear_pend_s  = 1'b0;
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        gap_d         = gap_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_q) begin
                    state_d      = S_PREFILL;
                    row_d        = '0;
                    col_d        = '0;
                    clear_pend_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_PREFILL, S_ROW: begin
                if (col_q == CW'(IMG_W-1)) begin
                    col_d = '0;
                    row_d = row_q + NW'(1);
                    if ((state_q == S_ROW) || (row_q == NW'(PREFILL_ROWS-1))) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES-1)) begin
                    if (row_q == NW'(IMG_H)) begin
                        state_d = S_DONE;
                    end else if ((pend_q != '0) || inc_s) begin
                        // a request landing on the last gap cycle still counts
                        state_d = S_ROW;
                        dec_s   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_WAIT: begin
                if (edge_s) begin
                    state_d = S_ROW;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear_pend_s || i_abort) begin
            pend_d = '0;
        end else begin
            pend_d = pend_q + NW'(inc_s) - NW'(dec_s);
        end

        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end

        start_d     = i_start & ~i_abort;
        intr_d      = i_intr;
        intr_prev_d = intr_q;

        phys_row_s = (FLIP_V != 0) ? (AW'(IMG_H-1) - AW'(row_q)) : AW'(row_q);
        rd_addr_s  = phys_row_s * AW'(IMG_W) + AW'(col_q);

        valid_d   = streaming_s & ~i_abort;
        data_d    = streaming_s ? mem_q[rd_addr_s] : data_q;
        row_idx_d = (streaming_s && (col_q == '0)) ? RW'(row_q) : row_idx_q;
        busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE));
        done_d    = (state_d == S_DONE);
        wr_ok_s   = i_wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)) && !i_abort;
    end

    // Control and output registers
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            pend_q      <= '0;
            col_q       <= '0;
            gap_q       <= '0;
            start_q     <= 1'b0;
            intr_q      <= 1'b0;
            intr_prev_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            row_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            pend_q      <= pend_d;
            col_q       <= col_d;
            gap_q       <= gap_d;
            start_q     <= start_d;
            intr_q      <= intr_d;
            intr_prev_q <= intr_prev_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            row_idx_q   <= row_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Frame storage; contents survive reset and abort
    always_ff @(posedge axi_clk) begin
        if (wr_ok_s) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_row_idx    = row_idx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_img_row_streamer.sv
// Bench for img_row_streamer: two instances (FLIP_V=1 and FLIP_V=0) share stimulus
// and are checked cycle by cycle against a row-schedule model built from request times.
module tb_img_row_streamer;
    localparam int W = 28, H = 28, P = 4, G = 1, N = W * H, MAXT = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, start = 1'b0, abort = 1'b0, intr = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] d1, d0;
    logic [4:0] r1, r0;
    logic       v1, v0, b1, b0, dn1, dn0;

    always #5 clk = ~clk;

    img_row_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .PREFILL_ROWS(P), .FLIP_V(1), .GAP_CYCLES(G)) dut1 (
        .axi_clk(clk), .axi_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_start(start), .i_abort(abort), .i_intr(intr), .o_data(d1), .o_data_valid(v1),
        .o_row_idx(r1), .o_busy(b1), .o_done(dn1));

    img_row_streamer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .PREFILL_ROWS(P), .FLIP_V(0), .GAP_CYCLES(G)) dut0 (
        .axi_clk(clk), .axi_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_start(start), .i_abort(abort), .i_intr(intr), .o_data(d0), .o_data_valid(v0),
        .o_row_idx(r0), .o_busy(b0), .o_done(dn0));

    int n_chk = 0;
    int n_fail = 0;
    int mem_m [N];
    int req_q [$];
    bit req_at [MAXT];
    int abort_rel = -1, start_rel = -1, wr_rel = -1;

    typedef struct {
        int   t;
        logic valid;
        int   pix1;
        int   pix0;
        int   ridx;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_pix(input int flip, input int r, input int c);
        int pr;
        pr = (flip != 0) ? (H - 1 - r) : r;
        return mem_m[pr * W + c];
    endfunction

    // Start a frame at rel 0 and check every following cycle against the row schedule
    task automatic run_scn(input string tag);
        int rs [H];
        int dn, last, m, er, ec;
        logic ev;
        for (int r = 0; r < P; r++) rs[r] = 2 + r * W;
        for (int j = P; j < H; j++) begin
            last = rs[j-1] + W - 1;
            m = req_q[j-P];
            rs[j] = (m + 1 <= last + G) ? (last + G + 1) : (m + 2);
        end
        dn = rs[H-1] + W - 1 + G;
        for (int i = 0; i < MAXT; i++) req_at[i] = 1'b0;
        foreach (req_q[i]) req_at[req_q[i]] = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= dn + 3; t++) begin
            intr = req_at[t];
            abort = (t == abort_rel);
            start = (t == start_rel);
            wr_en = (t == wr_rel);
            wr_addr = 10'd756;
            wr_data = 8'h55;
            step();
            intr = 1'b0; abort = 1'b0; start = 1'b0; wr_en = 1'b0;
            if (t == abort_rel) begin
                chk($sformatf("%s abort valid", tag), {31'd0, v1}, 32'd0);
                chk($sformatf("%s abort busy", tag), {31'd0, b1}, 32'd0);
                chk($sformatf("%s abort done", tag), {31'd0, dn1}, 32'd0);
                return;
            end
            ev = 1'b0; er = 0; ec = 0;
            for (int r = 0; r < H; r++) begin
                if (t >= rs[r] && t < rs[r] + W) begin
                    ev = 1'b1; er = r; ec = t - rs[r];
                end
            end
            chk($sformatf("%s valid1 t=%0d", tag, t), {31'd0, v1}, {31'd0, ev});
            chk($sformatf("%s valid0 t=%0d", tag, t), {31'd0, v0}, {31'd0, ev});
            if (ev) begin
                chk($sformatf("%s data1 t=%0d", tag, t), {24'd0, d1}, exp_pix(1, er, ec));
                chk($sformatf("%s data0 t=%0d", tag, t), {24'd0, d0}, exp_pix(0, er, ec));
                chk($sformatf("%s row1 t=%0d", tag, t), {27'd0, r1}, er);
                chk($sformatf("%s row0 t=%0d", tag, t), {27'd0, r0}, er);
            end
            chk($sformatf("%s busy t=%0d", tag, t), {31'd0, b1}, {31'd0, (t < dn)});
            chk($sformatf("%s done t=%0d", tag, t), {31'd0, dn1}, {31'd0, (t >= dn)});
        end
    endtask

    // Each request arrives only after the previous row has finished (block sits in WAIT)
    task automatic gen_wait(input int first_delay);
        int m;
        req_q.delete();
        m = (2 + P * W - 1) + G + first_delay;
        for (int j = 0; j < H - P; j++) begin
            req_q.push_back(m);
            m = m + 2 + W - 1 + G + int'($urandom_range(1, 30));
        end
    endtask

    task automatic gen_rand(input int first);
        int m;
        req_q.delete();
        m = first;
        for (int j = 0; j < H - P; j++) begin
            req_q.push_back(m);
            m = m + int'($urandom_range(2, 60));
        end
    endtask

    initial begin
        tbl[0] = '{1,   1'b0, 0,   0,   0};
        tbl[1] = '{2,   1'b1, 244, 0,   0};
        tbl[2] = '{3,   1'b1, 245, 1,   0};
        tbl[3] = '{29,  1'b1, 15,  27,  0};
        tbl[4] = '{30,  1'b1, 216, 28,  1};
        tbl[5] = '{86,  1'b1, 160, 84,  3};
        tbl[6] = '{113, 1'b1, 187, 111, 3};
        tbl[7] = '{114, 1'b0, 0,   0,   0};

        repeat (3) step();
        chk("reset data", {24'd0, d1}, 32'd0);
        chk("reset valid", {31'd0, v1}, 32'd0);
        chk("reset row_idx", {27'd0, r1}, 32'd0);
        chk("reset busy", {31'd0, b1}, 32'd0);
        chk("reset done", {31'd0, dn1}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post-reset busy", {31'd0, b0}, 32'd0);

        for (int a = 0; a < N; a++) begin
            wr_en = 1'b1; wr_addr = 10'(a); wr_data = 8'(a % 256);
            mem_m[a] = a % 256;
            step();
        end
        wr_en = 1'b0;

        // Prefill burst spot checks for both orientations
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 114; t++) begin
            step();
            if (t == 1) chk("prefill busy k+1", {31'd0, b1}, 32'd1);
            for (int i = 0; i < 8; i++) begin
                if (tbl[i].t == t) begin
                    chk($sformatf("tbl valid1 t=%0d", t), {31'd0, v1}, {31'd0, tbl[i].valid});
                    chk($sformatf("tbl valid0 t=%0d", t), {31'd0, v0}, {31'd0, tbl[i].valid});
                    if (tbl[i].valid) begin
                        chk($sformatf("tbl data1 t=%0d", t), {24'd0, d1}, tbl[i].pix1);
                        chk($sformatf("tbl data0 t=%0d", t), {24'd0, d0}, tbl[i].pix0);
                        chk($sformatf("tbl row1 t=%0d", t), {27'd0, r1}, tbl[i].ridx);
                        chk($sformatf("tbl row0 t=%0d", t), {27'd0, r0}, tbl[i].ridx);
                    end
                end
            end
        end
        repeat (40) step();
        chk("wait idle valid", {31'd0, v1}, 32'd0);
        chk("wait busy", {31'd0, b1}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort from wait busy", {31'd0, b1}, 32'd0);

        // Three requests during prefill, a fourth during row 5; start and write while busy
        req_q.delete();
        req_q.push_back(10); req_q.push_back(20); req_q.push_back(30); req_q.push_back(150);
        begin
            int m;
            m = 240;
            for (int j = 4; j < H - P; j++) begin
                req_q.push_back(m);
                m = m + int'($urandom_range(2, 60));
            end
        end
        start_rel = 50; wr_rel = 60;
        run_scn("queued");
        start_rel = -1; wr_rel = -1;

        gen_wait(200);
        run_scn("waitrow");

        wr_en = 1'b1; wr_addr = 10'd756; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        mem_m[756] = 8'h55;

        gen_rand(int'($urandom_range(2, 120)));
        run_scn("random");

        req_q.delete();
        for (int j = 0; j < H - P; j++) req_q.push_back(2 + 2 * j);
        abort_rel = 294;
        run_scn("abort");
        abort_rel = -1;
        repeat (5) step();
        chk("after abort valid", {31'd0, v0}, 32'd0);
        chk("after abort done", {31'd0, dn0}, 32'd0);

        gen_wait(60);
        run_scn("replay");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
